mul_alu_seq: RTL

- Multicycle sequencer for the LEGv8 MUL instruction (low 64 bits of the product); iterative shift-add.
- Borrows the shared EX-stage ALU for every accumulate step, so the datapath has no dedicated adder.
- Owns the ALU operand and control mux while busy, and asserts a stall to the hazard unit until the product is ready.
- Sits in EX beside ALU_control. EX selects the mux outputs of this block over the normal ALU_control path whenever alu_own is high.

---
 rtl/mul_alu_seq_pkg.sv | 20 ++
 rtl/mul_alu_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mul_alu_seq_pkg.sv
// Shared EX-stage ALU codes, MUL opcode and the MUL sequencer state encoding.
// Imported by the sequencer and by anything that decodes its ALU requests.
package mul_alu_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [10:0] OP_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_alu_seq.sv
// Iterative shift-add MUL sequencer that borrows the EX-stage ALU
// for every accumulate step and stalls the pipeline while busy.
module mul_alu_seq
  import mul_alu_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  mul_state_t r_state;
  mul_state_t w_state_nx;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_mcand_nx;
  logic [WIDTH-1:0] w_mplier_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [WIDTH-1:0] w_result_nx;

  logic             w_add;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_mplier_sh;
  logic             w_last;

  assign w_add       = r_mplier[0];
  assign w_step      = w_add ? alu_result : r_acc;
  assign w_mplier_sh = r_mplier >> 1;
  // Early-out once no multiplier bits remain, or after WIDTH steps.
  assign w_last      = (w_mplier_sh == '0) ||
                       (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nx  = r_state;
    w_acc_nx    = r_acc;
    w_mcand_nx  = r_mcand;
    w_mplier_nx = r_mplier;
    w_cnt_nx    = r_cnt;
    w_result_nx = r_result;
    unique case (r_state)
      MUL_IDLE: begin
        if (start && !abort) begin
          w_acc_nx    = '0;
          w_mcand_nx  = op_a;
          w_mplier_nx = op_b;
          w_cnt_nx    = '0;
          if (op_b == '0) begin
            w_state_nx  = MUL_DONE;
            w_result_nx = '0;
          end else begin
            w_state_nx  = MUL_RUN;
          end
        end
      end
      MUL_RUN: begin
        if (abort) begin
          w_state_nx = MUL_IDLE;
        end else begin
          w_acc_nx    = w_step;
          w_mcand_nx  = r_mcand << 1;
          w_mplier_nx = w_mplier_sh;
          w_cnt_nx    = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_state_nx  = MUL_DONE;
            w_result_nx = w_step;
          end
        end
      end
      MUL_DONE: begin
        w_state_nx = MUL_IDLE;
      end
      default: begin
        w_state_nx = MUL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MUL_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_acc    <= w_acc_nx;
      r_mcand  <= w_mcand_nx;
      r_mplier <= w_mplier_nx;
      r_cnt    <= w_cnt_nx;
      r_result <= w_result_nx;
    end
  end

  // Outputs decode from state and registers only.
  assign alu_own = (r_state == MUL_RUN);
  assign alu_a   = alu_own ? r_acc : '0;
  assign alu_b   = alu_own ? r_mcand : '0;
  assign alu_ctl = (alu_own && w_add) ? ALU_ADD : ALU_NONE;
  assign busy    = (r_state != MUL_IDLE);
  assign done    = (r_state == MUL_DONE);
  assign result  = r_result;

endmodule
